// File: rtl/hazard_detection_unit_priv_pkg.sv
// Shared opcode constants for the privileged in-order pipeline hazard logic.
package hazard_detection_unit_priv_pkg;
   localparam logic [6:0] R_TYPE = 7'b0110011;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] JALR   = 7'b1100111;
   localparam logic [6:0] JAL    = 7'b1101111;
endpackage

// File: rtl/hazard_detection_unit_priv.sv
// Combinational stall/flush detector for the fault-capable in-order pipeline.
// The only state is a half-rate cycle counter that gates scan debug printing.
module hazard_detection_unit_priv
   import hazard_detection_unit_priv_pkg::*;
#(
   parameter int CORE            = 0,
   parameter int ADDRESS_BITS    = 20,
   parameter int SCAN_CYCLES_MIN = 0,
   parameter int SCAN_CYCLES_MAX = 1000
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    fetch_valid,
   input  logic                    fetch_ready,
   input  logic                    issue_request,
   input  logic [ADDRESS_BITS-1:0] issue_PC,
   input  logic [ADDRESS_BITS-1:0] fetch_address_in,
   input  logic                    memory_valid,
   input  logic                    memory_ready,
   input  logic                    load_memory,
   input  logic                    store_memory,
   input  logic [ADDRESS_BITS-1:0] load_address,
   input  logic [ADDRESS_BITS-1:0] memory_address_in,
   input  logic [6:0]              opcode_decode,
   input  logic [6:0]              opcode_execute,
   input  logic                    branch_execute,
   input  logic                    solo_instr_decode,
   input  logic                    solo_instr_execute,
   input  logic                    solo_instr_memory_issue,
   input  logic                    solo_instr_memory_receive,
   input  logic                    solo_instr_writeback,
   input  logic                    i_mem_page_fault,
   input  logic                    i_mem_access_fault,
   input  logic                    d_mem_page_fault,
   input  logic                    d_mem_access_fault,
   output logic                    i_mem_issue_hazard,
   output logic                    i_mem_recv_hazard,
   output logic                    d_mem_issue_hazard,
   output logic                    d_mem_recv_hazard,
   output logic                    JALR_branch_hazard,
   output logic                    JAL_hazard,
   output logic                    solo_instr_hazard,
   input  logic                    scan
);

   logic        i_fault;
   logic        d_fault;
   logic [31:0] cycles;
   logic        phase;

   // A pending fault must reach the trap logic, so it suppresses the memory stall on its side.
   assign i_fault = i_mem_page_fault | i_mem_access_fault;
   assign d_fault = d_mem_page_fault | d_mem_access_fault;

   assign i_mem_issue_hazard = ~i_fault & ~fetch_ready & ~issue_request;
   assign i_mem_recv_hazard  = ~i_fault & issue_request &
                               (~fetch_valid | (issue_PC != fetch_address_in));
   assign d_mem_issue_hazard = ~d_fault & ~memory_ready;
   assign d_mem_recv_hazard  = ~d_fault & load_memory &
                               (~memory_valid | (load_address != memory_address_in));

   assign JALR_branch_hazard = (opcode_execute == JALR) |
                               ((opcode_execute == BRANCH) & branch_execute);
   assign JAL_hazard         = (opcode_decode == JAL);

   // Decode holds until every older solo instruction has left the pipeline.
   assign solo_instr_hazard  = solo_instr_execute | solo_instr_memory_issue |
                               solo_instr_memory_receive | solo_instr_writeback;

   always_ff @(posedge clock) begin
      if (reset) begin
         cycles <= 32'd0;
         phase  <= 1'b0;
      end else begin
         phase <= ~phase;
         if (phase) cycles <= cycles + 32'd1;
      end
   end

`ifndef SYNTHESIS
   logic in_window;
   // Signed 33-bit compare keeps the window check meaningful for any parameter values.
   assign in_window = ($signed({1'b0, cycles}) >= 33'(SCAN_CYCLES_MIN)) &&
                      ($signed({1'b0, cycles}) <= 33'(SCAN_CYCLES_MAX));

   always @(posedge clock) begin
      if (scan && in_window) begin
         $display("hdu core=%0d cycle=%0d fv=%b fr=%b ireq=%b ipc=%h faddr=%h mv=%b mr=%b ld=%b st=%b laddr=%h maddr=%h opd=%b ope=%b br=%b solo=%b%b%b%b%b flt=%b%b%b%b | iiss=%b irecv=%b diss=%b drecv=%b jalr_br=%b jal=%b solo_h=%b",
                  CORE, cycles, fetch_valid, fetch_ready, issue_request, issue_PC,
                  fetch_address_in, memory_valid, memory_ready, load_memory, store_memory,
                  load_address, memory_address_in, opcode_decode, opcode_execute,
                  branch_execute, solo_instr_decode, solo_instr_execute,
                  solo_instr_memory_issue, solo_instr_memory_receive, solo_instr_writeback,
                  i_mem_page_fault, i_mem_access_fault, d_mem_page_fault, d_mem_access_fault,
                  i_mem_issue_hazard, i_mem_recv_hazard, d_mem_issue_hazard,
                  d_mem_recv_hazard, JALR_branch_hazard, JAL_hazard, solo_instr_hazard);
      end
   end
`endif

endmodule

// File: tb/tb_hazard_detection_unit_priv.sv
// Scoreboard bench: each driven vector pushes its expected hazard vector, the
// negedge monitor pops and compares it against the DUT outputs.
module tb_hazard_detection_unit_priv;
   import hazard_detection_unit_priv_pkg::*;

   localparam int AW = 20;

   logic          clock = 1'b0;
   logic          reset;
   logic          fetch_valid, fetch_ready, issue_request;
   logic [AW-1:0] issue_PC, fetch_address_in;
   logic          memory_valid, memory_ready, load_memory, store_memory;
   logic [AW-1:0] load_address, memory_address_in;
   logic [6:0]    opcode_decode, opcode_execute;
   logic          branch_execute;
   logic          solo_instr_decode, solo_instr_execute, solo_instr_memory_issue;
   logic          solo_instr_memory_receive, solo_instr_writeback;
   logic          i_mem_page_fault, i_mem_access_fault, d_mem_page_fault, d_mem_access_fault;
   logic          i_mem_issue_hazard, i_mem_recv_hazard, d_mem_issue_hazard, d_mem_recv_hazard;
   logic          JALR_branch_hazard, JAL_hazard, solo_instr_hazard;
   logic          scan;

   logic [6:0] exp_q[$];
   string      tag_q[$];
   int         checks = 0;
   int         errors = 0;

   always #5 clock = ~clock;

   hazard_detection_unit_priv #(.CORE(0), .ADDRESS_BITS(AW),
                                .SCAN_CYCLES_MIN(0), .SCAN_CYCLES_MAX(1000)) dut (
      .clock(clock), .reset(reset),
      .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .issue_request(issue_request),
      .issue_PC(issue_PC), .fetch_address_in(fetch_address_in),
      .memory_valid(memory_valid), .memory_ready(memory_ready),
      .load_memory(load_memory), .store_memory(store_memory),
      .load_address(load_address), .memory_address_in(memory_address_in),
      .opcode_decode(opcode_decode), .opcode_execute(opcode_execute),
      .branch_execute(branch_execute),
      .solo_instr_decode(solo_instr_decode), .solo_instr_execute(solo_instr_execute),
      .solo_instr_memory_issue(solo_instr_memory_issue),
      .solo_instr_memory_receive(solo_instr_memory_receive),
      .solo_instr_writeback(solo_instr_writeback),
      .i_mem_page_fault(i_mem_page_fault), .i_mem_access_fault(i_mem_access_fault),
      .d_mem_page_fault(d_mem_page_fault), .d_mem_access_fault(d_mem_access_fault),
      .i_mem_issue_hazard(i_mem_issue_hazard), .i_mem_recv_hazard(i_mem_recv_hazard),
      .d_mem_issue_hazard(d_mem_issue_hazard), .d_mem_recv_hazard(d_mem_recv_hazard),
      .JALR_branch_hazard(JALR_branch_hazard), .JAL_hazard(JAL_hazard),
      .solo_instr_hazard(solo_instr_hazard), .scan(scan)
   );

   // Packed order: {i_issue, i_recv, d_issue, d_recv, jalr_branch, jal, solo}
   localparam logic [6:0] H_I_ISS  = 7'b1000000;
   localparam logic [6:0] H_I_RECV = 7'b0100000;
   localparam logic [6:0] H_D_ISS  = 7'b0010000;
   localparam logic [6:0] H_D_RECV = 7'b0001000;
   localparam logic [6:0] H_JALR   = 7'b0000100;
   localparam logic [6:0] H_JAL    = 7'b0000010;
   localparam logic [6:0] H_SOLO   = 7'b0000001;

   task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%b expected=%b", tag, got, exp);
      end
   endtask

   // Independent reference written case-by-case from the hazard rules.
   function automatic logic [6:0] model();
      logic [6:0] r;
      r = '0;
      if (!(i_mem_page_fault || i_mem_access_fault)) begin
         if (!fetch_ready && !issue_request) r |= H_I_ISS;
         if (issue_request) begin
            if (!fetch_valid) r |= H_I_RECV;
            else if (issue_PC != fetch_address_in) r |= H_I_RECV;
         end
      end
      if (!(d_mem_page_fault || d_mem_access_fault)) begin
         if (!memory_ready) r |= H_D_ISS;
         if (load_memory) begin
            if (!memory_valid) r |= H_D_RECV;
            else if (load_address != memory_address_in) r |= H_D_RECV;
         end
      end
      case (opcode_execute)
         JALR:    r |= H_JALR;
         BRANCH:  if (branch_execute) r |= H_JALR;
         default: ;
      endcase
      if (opcode_decode == JAL) r |= H_JAL;
      if (solo_instr_execute || solo_instr_memory_issue ||
          solo_instr_memory_receive || solo_instr_writeback) r |= H_SOLO;
      return r;
   endfunction

   always @(negedge clock) begin
      while (exp_q.size() > 0) begin
         check(tag_q.pop_front(),
               {i_mem_issue_hazard, i_mem_recv_hazard, d_mem_issue_hazard, d_mem_recv_hazard,
                JALR_branch_hazard, JAL_hazard, solo_instr_hazard},
               exp_q.pop_front());
      end
   end

   task automatic set_idle();
      fetch_valid = 1; fetch_ready = 1; issue_request = 0;
      issue_PC = '0; fetch_address_in = '0;
      memory_valid = 1; memory_ready = 1; load_memory = 0; store_memory = 0;
      load_address = '0; memory_address_in = '0;
      opcode_decode = R_TYPE; opcode_execute = R_TYPE; branch_execute = 0;
      solo_instr_decode = 0; solo_instr_execute = 0; solo_instr_memory_issue = 0;
      solo_instr_memory_receive = 0; solo_instr_writeback = 0;
      i_mem_page_fault = 0; i_mem_access_fault = 0;
      d_mem_page_fault = 0; d_mem_access_fault = 0;
   endtask

   // Push the expectation for the inputs just driven; the monitor consumes it at the next negedge.
   task automatic expect_vec(input string tag, input logic [6:0] exp);
      exp_q.push_back(exp);
      tag_q.push_back(tag);
      @(negedge clock);
      #1;
   endtask

   initial begin
      scan = 0;
      reset = 1;
      set_idle();
      @(negedge clock); #1;
      expect_vec("reset_idle", '0);
      reset = 0;
      expect_vec("idle", '0);

      fetch_valid = 0; fetch_ready = 0;
      expect_vec("i_issue", H_I_ISS);

      issue_request = 1; i_mem_page_fault = 1;
      expect_vec("i_pf_mask", '0);
      i_mem_page_fault = 0; i_mem_access_fault = 1;
      expect_vec("i_af_mask", '0);
      i_mem_access_fault = 0;
      expect_vec("i_recv_invalid", H_I_RECV);

      set_idle();
      issue_request = 1; issue_PC = 20'h00100; fetch_address_in = 20'h00104;
      expect_vec("i_recv_addr", H_I_RECV);
      fetch_address_in = 20'h00100;
      expect_vec("i_recv_match", '0);

      set_idle();
      load_memory = 1; memory_valid = 0;
      expect_vec("d_recv", H_D_RECV);
      d_mem_page_fault = 1;
      expect_vec("d_pf_mask", '0);
      d_mem_page_fault = 0; memory_valid = 1; load_address = 20'h0abcd;
      memory_address_in = 20'h0abce;
      expect_vec("d_recv_addr", H_D_RECV);
      memory_address_in = 20'h0abcd;
      expect_vec("d_recv_match", '0);
      load_memory = 0; memory_ready = 0;
      expect_vec("d_issue", H_D_ISS);
      d_mem_access_fault = 1;
      expect_vec("d_af_mask", '0);

      set_idle();
      opcode_execute = BRANCH; branch_execute = 0;
      expect_vec("branch_not_taken", '0);
      branch_execute = 1;
      expect_vec("branch_taken", H_JALR);
      opcode_execute = JALR; branch_execute = 0;
      expect_vec("jalr", H_JALR);
      opcode_execute = R_TYPE; branch_execute = 1;
      expect_vec("rtype_br_flag", '0);
      opcode_decode = JAL;
      branch_execute = 0;
      expect_vec("jal", H_JAL);
      opcode_decode = R_TYPE; solo_instr_writeback = 1;
      expect_vec("solo_wb", H_SOLO);
      solo_instr_writeback = 0; solo_instr_execute = 1;
      expect_vec("solo_ex", H_SOLO);
      solo_instr_execute = 0; solo_instr_decode = 1;
      expect_vec("solo_decode_only", '0);

      // Faults must not hide control or solo hazards.
      set_idle();
      i_mem_page_fault = 1; d_mem_access_fault = 1; fetch_ready = 0; memory_ready = 0;
      opcode_decode = JAL; opcode_execute = JALR; solo_instr_memory_receive = 1;
      expect_vec("fault_no_ctrl_mask", H_JALR | H_JAL | H_SOLO);

      set_idle();
      solo_instr_decode = 1'bx; store_memory = 1'bx;
      expect_vec("x_on_unused", '0);

      for (int i = 0; i < 60; i++) begin
         fetch_valid = 1'($urandom_range(0, 1));
         fetch_ready = 1'($urandom_range(0, 1));
         issue_request = 1'($urandom_range(0, 1));
         issue_PC = 20'($urandom_range(0, 3));
         fetch_address_in = 20'($urandom_range(0, 3));
         memory_valid = 1'($urandom_range(0, 1));
         memory_ready = 1'($urandom_range(0, 1));
         load_memory = 1'($urandom_range(0, 1));
         store_memory = 1'($urandom_range(0, 1));
         load_address = 20'($urandom_range(0, 3)) << 18;
         memory_address_in = 20'($urandom_range(0, 3)) << 18;
         case ($urandom_range(0, 3))
            0: opcode_execute = BRANCH;
            1: opcode_execute = JALR;
            2: opcode_execute = JAL;
            default: opcode_execute = R_TYPE;
         endcase
         opcode_decode = ($urandom_range(0, 2) == 0) ? JAL : 7'($urandom_range(0, 127));
         branch_execute = 1'($urandom_range(0, 1));
         solo_instr_decode = 1'($urandom_range(0, 1));
         solo_instr_execute = ($urandom_range(0, 5) == 0);
         solo_instr_memory_issue = ($urandom_range(0, 5) == 0);
         solo_instr_memory_receive = ($urandom_range(0, 5) == 0);
         solo_instr_writeback = ($urandom_range(0, 5) == 0);
         i_mem_page_fault = ($urandom_range(0, 4) == 0);
         i_mem_access_fault = ($urandom_range(0, 4) == 0);
         d_mem_page_fault = ($urandom_range(0, 4) == 0);
         d_mem_access_fault = ($urandom_range(0, 4) == 0);
         expect_vec($sformatf("rand_%0d", i), model());
      end

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clock);
      if (exp_q.size() > 0) begin
         errors++;
         checks++;
         $display("FAIL drain: got=%0d pending expected=0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
